// File: rtl/fpdiv_arbiter.sv
// Round-robin arbiter and sequencer sharing one fpdiv divider between NREQ requesters.
// Each operation restarts the divider, waits for done under a timeout and returns a tagged result.
module fpdiv_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TW      = $clog2(NREQ)
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [NREQ-1:0]    REQ,
  input  logic [32*NREQ-1:0] REQ_A,
  input  logic [32*NREQ-1:0] REQ_B,
  output logic [NREQ-1:0]    GNT,
  output logic               BUSY,
  output logic               RES_VALID,
  input  logic               RES_READY,
  output logic [TW-1:0]      RES_TAG,
  output logic [31:0]        RES_DATA,
  output logic [1:0]         RES_EXC,
  output logic               RES_TIMEOUT,
  output logic [31:0]        DIV_A,
  output logic [31:0]        DIV_B,
  output logic               DIV_RSTN,
  input  logic               DIV_DONE,
  input  logic [31:0]        DIV_Q,
  input  logic [1:0]         DIV_EXC
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StResp} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              rstn_q, rstn_d;
  logic [TW-1:0]     tag_q, tag_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        exc_q, exc_d;
  logic              tmo_q, tmo_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;

  logic              found;
  logic [TW-1:0]     pick;
  int unsigned       idx;

  // First requester at or above ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && REQ[idx]) begin
        found = 1'b1;
        pick  = TW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    tag_d   = tag_q;
    data_d  = data_q;
    exc_d   = exc_q;
    tmo_d   = tmo_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          a_d         = REQ_A[32*pick +: 32];
          b_d         = REQ_B[32*pick +: 32];
          tag_d       = pick;
          ptr_d       = (pick == TW'(NREQ - 1)) ? '0 : pick + 1'b1;
          gnt_d[pick] = 1'b1;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        // A done seen at cnt 0 is left over from before the restart.
        if (DIV_DONE && (cnt_q != '0)) begin
          data_d  = DIV_Q;
          exc_d   = DIV_EXC;
          tmo_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          data_d  = '0;
          exc_d   = 2'b11;
          tmo_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (RES_READY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d  = (state_d != StIdle);
    valid_d = (state_d == StResp);
    rstn_d  = (state_d == StRun);
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      rstn_q  <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      exc_q   <= '0;
      tmo_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      rstn_q  <= rstn_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
      tmo_q   <= tmo_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign GNT         = gnt_q;
  assign BUSY        = busy_q;
  assign RES_VALID   = valid_q;
  assign RES_TAG     = tag_q;
  assign RES_DATA    = data_q;
  assign RES_EXC     = exc_q;
  assign RES_TIMEOUT = tmo_q;
  assign DIV_A       = a_q;
  assign DIV_B       = b_q;
  assign DIV_RSTN    = rstn_q;

endmodule
